life_engine: RTL

Parametrised cellular-automaton step engine with row-parallel in-place update, runtime birth/survive rules, and selectable toroidal or dead-border boundary. It holds a 2^LOG_W × 2^LOG_H board and computes one full row per clock, so a generation costs 2^LOG_H + 2 cycles instead of ~9 per cell plus a copy pass. A VGA renderer reads it through a registered row read port. A frame-timer controller issues STEP, RANDOMIZE and CLEAR commands through a valid/ready handshake.

---
 rtl/life_pkg.sv | 27 ++
 rtl/life_row_next.sv | 30 +++
 rtl/life_engine.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/life_pkg.sv
// Shared types and constants for the life_engine cellular-automaton step engine.
package life_pkg;

  typedef enum logic [1:0] {
    OP_STEP  = 2'd0,
    OP_RAND  = 2'd1,
    OP_CLEAR = 2'd2,
    OP_NOP   = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_SETUP,
    S_ROW,
    S_FILL
  } state_e;

  localparam logic [8:0] CONWAY_BIRTH   = 9'b000001000;
  localparam logic [8:0] CONWAY_SURVIVE = 9'b000001100;

  function automatic logic [3:0] cnt8(input logic [7:0] v);
    cnt8 = '0;
    for (int i = 0; i < 8; i++) cnt8 = cnt8 + {3'b000, v[i]};
  endfunction

endpackage

// File: rtl/life_row_next.sv
// Combinational next-generation row: counts the 8 neighbours of every cell and applies the masks.
module life_row_next
  import life_pkg::*;
#(
  parameter int LOG_W = 6,
  parameter int WRAP  = 1
) (
  input  logic [(1<<LOG_W)-1:0] prev_i,
  input  logic [(1<<LOG_W)-1:0] cur_i,
  input  logic [(1<<LOG_W)-1:0] below_i,
  input  logic [8:0]            birth_i,
  input  logic [8:0]            survive_i,
  output logic [(1<<LOG_W)-1:0] next_o
);
  localparam int W = 1 << LOG_W;

  // Rows padded by one cell on each side; pads hold the wrapped cell or a dead one.
  logic [W+1:0] ep, ec, eb;

  assign ep = {(WRAP != 0) ? prev_i[0]  : 1'b0, prev_i,  (WRAP != 0) ? prev_i[W-1]  : 1'b0};
  assign ec = {(WRAP != 0) ? cur_i[0]   : 1'b0, cur_i,   (WRAP != 0) ? cur_i[W-1]   : 1'b0};
  assign eb = {(WRAP != 0) ? below_i[0] : 1'b0, below_i, (WRAP != 0) ? below_i[W-1] : 1'b0};

  for (genvar i = 0; i < W; i++) begin : g_cell
    logic [3:0] n;
    assign n         = cnt8({ep[i+2:i], eb[i+2:i], ec[i+2], ec[i]});
    assign next_o[i] = cur_i[i] ? survive_i[n] : birth_i[n];
  end

endmodule

// File: rtl/life_engine.sv
// Row-parallel in-place life engine: one row per clock for STEP, LFSR/zero fill for RANDOMIZE/CLEAR.
module life_engine
  import life_pkg::*;
#(
  parameter int          LOG_W = 6,
  parameter int          LOG_H = 5,
  parameter int          WRAP  = 1,
  parameter logic [31:0] SEED  = 32'h0000_0001
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid_i,
  input  logic [1:0]               cmd_op_i,
  output logic                     cmd_ready_o,
  input  logic [8:0]               birth_mask_i,
  input  logic [8:0]               survive_mask_i,
  output logic                     done_o,
  input  logic                     wr_en_i,
  input  logic [LOG_H-1:0]         wr_row_i,
  input  logic [(1<<LOG_W)-1:0]    wr_data_i,
  input  logic [LOG_H-1:0]         rd_row_i,
  output logic [(1<<LOG_W)-1:0]    rd_data_o,
  output logic [LOG_W+LOG_H:0]     pop_count_o,
  output logic [15:0]              generation_o
);
  localparam int W  = 1 << LOG_W;
  localparam int H  = 1 << LOG_H;
  localparam int PW = LOG_W + LOG_H + 1;

  state_e           state_q, state_d;
  op_e              op;
  logic [LOG_H-1:0] row_q, row_nx, widx;
  logic [31:0]      lfsr_q;
  logic [8:0]       birth_q, survive_q;
  logic             clr_q, done_q, wen, accept, row_last;
  logic [PW-1:0]    acc_q, pop_q, row_pop;
  logic [15:0]      gen_q;
  logic [W-1:0]     rd_q, first_q, prev_q, cur, below, next_row, fill_pat, wval;
  logic [W-1:0]     board [H];

  assign op          = op_e'(cmd_op_i);
  assign accept      = cmd_valid_i && (state_q == S_IDLE);
  assign row_last    = &row_q;
  assign row_nx      = row_q + 1'b1;
  assign cur         = board[row_q];
  assign below       = row_last ? ((WRAP != 0) ? first_q : '0) : board[row_nx];

  assign cmd_ready_o  = (state_q == S_IDLE);
  assign done_o       = done_q;
  assign rd_data_o    = rd_q;
  assign pop_count_o  = pop_q;
  assign generation_o = gen_q;

  life_row_next #(.LOG_W(LOG_W), .WRAP(WRAP)) u_row_next (
    .prev_i   (prev_q),
    .cur_i    (cur),
    .below_i  (below),
    .birth_i  (birth_q),
    .survive_i(survive_q),
    .next_o   (next_row)
  );

  always_comb begin
    fill_pat = '0;
    for (int i = 0; i < W; i++) fill_pat[i] = lfsr_q[i % 32];
  end

  // Single board write port shared by fill, step and direct writes.
  always_comb begin
    wen  = 1'b0;
    widx = row_q;
    wval = next_row;
    unique case (state_q)
      S_INIT, S_FILL: begin
        wen  = 1'b1;
        wval = clr_q ? '0 : fill_pat;
      end
      S_ROW: wen = 1'b1;
      S_IDLE: if (wr_en_i && !cmd_valid_i) begin
        wen  = 1'b1;
        widx = wr_row_i;
        wval = wr_data_i;
      end
      default: ;
    endcase
  end

  always_comb begin
    row_pop = '0;
    for (int i = 0; i < W; i++) row_pop = row_pop + PW'(wval[i]);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_INIT, S_FILL, S_ROW: if (row_last) state_d = S_IDLE;
      S_SETUP: state_d = S_ROW;
      S_IDLE: if (cmd_valid_i) begin
        if (op == OP_STEP) state_d = S_SETUP;
        else if (op == OP_RAND || op == OP_CLEAR) state_d = S_FILL;
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_INIT;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (wen) board[widx] <= wval;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q     <= '0;
      lfsr_q    <= SEED;
      birth_q   <= '0;
      survive_q <= '0;
      clr_q     <= 1'b0;
      done_q    <= 1'b0;
      acc_q     <= '0;
      pop_q     <= '0;
      gen_q     <= '0;
      rd_q      <= '0;
      first_q   <= '0;
      prev_q    <= '0;
    end else begin
      lfsr_q <= {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};
      rd_q   <= board[rd_row_i];
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          row_q <= '0;
          acc_q <= '0;
          if (accept) begin
            birth_q   <= birth_mask_i;
            survive_q <= survive_mask_i;
            clr_q     <= (op == OP_CLEAR);
            done_q    <= (op == OP_NOP);
          end
        end
        S_SETUP: begin
          first_q <= board[0];
          prev_q  <= (WRAP != 0) ? board[H-1] : '0;
        end
        S_INIT, S_FILL, S_ROW: begin
          row_q  <= row_nx;
          acc_q  <= acc_q + row_pop;
          // Original row becomes the upper neighbour of the next row.
          prev_q <= cur;
          if (row_last) begin
            done_q <= 1'b1;
            pop_q  <= acc_q + row_pop;
            gen_q  <= (state_q == S_ROW) ? gen_q + 16'd1 : 16'd0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
